// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared constants and types for the data-memory / write-buffer slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    localparam int          IO_REGION_BIT = 16;
    localparam logic [16:0] STATUS_ADDR   = 17'h1FFFF;

    // Status word layout
    localparam int ST_COUNT_LSB = 0;
    localparam int ST_COUNT_W   = 8;
    localparam int ST_FULL_BIT  = 8;
    localparam int ST_EMPTY_BIT = 9;
    localparam int ST_DROP_LSB  = 16;
    localparam int DROP_CNT_W   = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wbuf_entry_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbuf_fifo.sv
// ---------------------------------------------------------------------------
// wbuf_fifo : circular posted-write FIFO; a push into a full FIFO is accepted
//             only when a pop retires the head on the same edge.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wbuf_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage has no reset; only the bookkeeping below is cleared.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_wbuf.sv
// ---------------------------------------------------------------------------
// dmem_wbuf : single-cycle data RAM plus posted I/O write buffer for the CPU
//             MEM stage. Define DMEM_WBUF_STATUS_EN to map a status register
//             at 0x1FFFF. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_mem,
    input  logic [16:0] mem_addr,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic        io_valid,
    output logic [15:0] io_addr,
    output logic [31:0] io_data,
    input  logic        io_ready,
    input  logic [31:0] io_rdata,
    output logic        io_drop
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]           ram [2**RAM_AW];
    logic [RAM_AW-1:0]     ram_idx;
    logic                  in_io;
    logic                  is_status;
    logic                  status_clr;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    wbuf_entry_t           push_entry;
    wbuf_entry_t           head_entry;
    logic                  drop;
    logic [DROP_CNT_W-1:0] drop_cnt;

    assign ram_idx = mem_addr[RAM_AW-1:0];
    assign in_io   = mem_addr[IO_REGION_BIT];

`ifdef DMEM_WBUF_STATUS_EN
    assign is_status = (mem_addr == STATUS_ADDR);
`else
    assign is_status = 1'b0;
`endif

    assign status_clr = wr_mem && is_status;
    assign fifo_push  = wr_mem && in_io && !is_status;
    assign fifo_pop   = io_ready && !fifo_empty;
    // A full buffer still takes the write if the head retires on this edge.
    assign drop       = fifo_push && fifo_full && !fifo_pop;

    assign push_entry.addr = mem_addr[15:0];
    assign push_entry.data = dout;

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wbuf_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign io_valid = (fifo_count != '0);
    assign io_addr  = head_entry.addr;
    assign io_data  = head_entry.data;

    always_ff @(posedge clk) begin
        if (wr_mem && !in_io)
            ram[ram_idx] <= dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_drop  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            io_drop <= drop;
            if (status_clr)
                drop_cnt <= '0;
            else if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

`ifdef DMEM_WBUF_STATUS_EN
    logic [31:0] status_word;

    always_comb begin
        status_word = '0;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
        status_word[ST_FULL_BIT]                = fifo_full;
        status_word[ST_EMPTY_BIT]               = fifo_empty;
        status_word[ST_DROP_LSB +: DROP_CNT_W]  = drop_cnt;
    end
`endif

    always_comb begin
        din = ram[ram_idx];
        if (in_io)
            din = io_rdata;
`ifdef DMEM_WBUF_STATUS_EN
        if (is_status)
            din = status_word;
`endif
    end

endmodule

`default_nettype wire

// File: doc/dmem_wbuf.md
# dmem_wbuf

Data-memory subsystem sitting directly downstream of the pipelined CPU's MEM-stage port (`wr_mem`, `mem_addr`, `dout`, `din`). Decodes each access into an on-chip data RAM or an I/O region. I/O writes are posted into a write buffer (FIFO) that drains to a slow external bus over a valid/ready handshake. The CPU cannot stall, so every access completes in the cycle it is presented; I/O writes that find the buffer full are dropped and counted.

## Interface

Parameters:
- `RAM_AW`, default 10: data RAM word-address width; depth is 2^`RAM_AW` words of 32 bits.
- `DEPTH`, default 8: write-buffer entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_mem`  in  1  CPU write strobe (MEM stage).
- `mem_addr`  in  17  CPU word address.
- `dout`  in  32  CPU write data.
- `din`  out  32  read data to CPU; combinational from `mem_addr`.
- `io_valid`  out  1  buffer head is valid.
- `io_addr`  out  16  head address, `mem_addr[15:0]`.
- `io_data`  out  32  head data.
- `io_ready`  in  1  external bus accepts the head.
- `io_rdata`  in  32  external read data for I/O-region reads.
- `io_drop`  out  1  registered one-cycle pulse: an I/O write was dropped.

## Operation

Address decode:
- `mem_addr[16]=0`: RAM region. The index is `mem_addr[RAM_AW-1:0]`. Bits `[15:RAM_AW]` are ignored, so higher addresses alias.
- `mem_addr[16]=1`: I/O region.

RAM region:
- Read: `din = ram[index]`, asynchronous.
- Write: `ram[index] <= dout` on the rising edge when `wr_mem` is high.
- Same-cycle read and write to one index: `din` shows the old data.
- RAM contents are not reset.

I/O region writes:
- When `wr_mem` is high, enqueue `{mem_addr[15:0], dout}`.
- If the buffer is full and no dequeue happens this cycle: drop the write, pulse `io_drop` the next cycle, and increment `drop_cnt` (8 bits, saturates at 255).
- If the buffer is full and a dequeue happens the same cycle: accept the write. Count is unchanged.

I/O region reads:
- `din = io_rdata`, passed through combinationally.

Write buffer:
- Circular FIFO with read and write pointers and a count of width log2(`DEPTH`)+1.
- `io_valid = (count != 0)`.
- `io_addr` and `io_data` are the head entry and must be stable while `io_valid` is high and `io_ready` is low.
- Dequeue happens on the rising edge when `io_valid && io_ready`.
- Pointers wrap modulo `DEPTH`.
- `io_ready` is ignored when the buffer is empty.

Reset values (all asynchronous):
- Pointers, count and `drop_cnt` clear to 0.
- `io_valid=0`, `io_drop=0`.
- A reset asserted mid-drain discards all pending entries.

## Timing

- Read latency is 0 cycles: `din` is valid in the same cycle as `mem_addr`, and the CPU samples it at the following edge.
- RAM write takes effect at the edge that ends the access cycle.
- Enqueue-to-`io_valid` latency is 1 cycle from an empty buffer.
- Throughput is one enqueue and one dequeue per cycle, simultaneously.
- `io_drop` is asserted in the cycle after the dropped access, for exactly one cycle.

## Configuration

- `DMEM_WBUF_STATUS_EN` defined: address `0x1FFFF` is a status register.
  - Read returns `{8'd0, drop_cnt, 6'd0, empty, full, count zero-extended to 8 bits}`.
  - Write is not enqueued; it clears `drop_cnt` to 0.
  - If the clear and a drop occur in the same cycle, the clear wins and `drop_cnt` becomes 0.
- `DMEM_WBUF_STATUS_EN` undefined: `0x1FFFF` is an ordinary I/O address (read returns `io_rdata`, write is enqueued). `drop_cnt` is still maintained internally but is not readable.

## Structure

- Shared package `dmem_pkg`:
  - `IO_REGION_BIT` (16)
  - `STATUS_ADDR` (17'h1FFFF)
  - status field offsets (count [7:0], full 8, empty 9, drop_cnt [23:16])
  - `DROP_CNT_W` (8)
- Sub-module `wbuf_fifo`: parameterised by `DEPTH` and width 48.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Implements the full-with-pop acceptance rule.
- Top level: address decode, RAM array, drop counter, status mux.

## Test plan

- RAM write/read: write `0x0005 <= 0xDEADBEEF`, then read `0x0005` → `din=0xDEADBEEF`.
  - Then read `0x0405` (alias at `RAM_AW=10`) → `0xDEADBEEF`.
  - Same-cycle read/write to one index returns the prior value.
- I/O post and drain: with `io_ready=0`, write `0x10010 <= 0x11`, then `0x10020 <= 0x22`.
  - `io_valid=1`, `io_addr=0x0010`, `io_data=0x11`, held stable.
  - Raise `io_ready` → entries drain in order; `io_valid=0` after two cycles.
- Overflow: with `io_ready=0`, issue 10 I/O writes at `DEPTH=8`.
  - Exactly 8 are buffered.
  - `io_drop` pulses twice.
  - Status read (with `DMEM_WBUF_STATUS_EN`) → `0x00020108`.
- Full with simultaneous pop: buffer full, `io_ready=1` plus one I/O write in the same cycle.
  - Write accepted, count stays 8, no `io_drop`.
  - Pointer wrap verified over 20 push/pop cycles with data integrity.
- Status clear and reset: write `0x1FFFF` → `drop_cnt=0` and nothing enqueued.
  - Assert `rst` with 3 entries pending → `io_valid=0` immediately, count 0, `io_drop=0`.
  - Without the macro, a write to `0x1FFFF` appears at `io_addr=0xFFFF`.
